program_sequencer_ctrl: RTL and testbench
=========================================

PROGRAM_SEQUENCER_CTRL -- requirements
Module: program_sequencer_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 jmp  input  1  unconditional jump request from the instruction decoder.
REQ-004 jmp_nz  input  1  conditional jump request; taken only when dont_jmp is 0.
REQ-005 jmp_addr  input  4  jump target nibble (decoder ir_nibble); target = {jmp_addr, 4'h0}.
REQ-006 dont_jmp  input  1  ALU zero flag; 1 suppresses jmp_nz.
REQ-007 halt_req  input  1  debug halt request, level-sampled.
REQ-008 run_req  input  1  debug resume request, level-sampled.
REQ-009 step_req  input  1  debug single-step request, level-sampled.
REQ-010 hist_sel  input  2  jump-history read index (used only with PS_HISTORY_EN).
REQ-011 pm_addr  output  8  combinational program-memory address for the next fetch.
REQ-012 pc  output  8  registered address of the current instruction.
REQ-013 exec_en  output  1  1 when the current instruction may commit; gates datapath register enables.
REQ-014 step_ack  output  1  one-cycle pulse when a single step executes.
REQ-015 seq_state  output  2  FSM state: 00 RUN, 01 HALT, 10 STEP.
REQ-016 from_PS  output  8  debug tap; equals pc.
REQ-017 hist_data  output  8  jump-history entry hist_sel (0 = most recent).
REQ-018 hist_count  output  3  number of valid history entries, saturating at 4.

Function
REQ-019 pc SHALL load pm_addr on every rising clk edge; pm_addr SHALL be combinational from pc, seq_state and jump inputs.
REQ-020 In RUN or STEP, pm_addr SHALL be {jmp_addr,4'h0} if jump taken, else pc+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-021 Jump taken = jmp OR (jmp_nz AND NOT dont_jmp); jmp SHALL take priority when both are asserted.
REQ-022 In HALT, pm_addr SHALL equal pc; jmp/jmp_nz SHALL be ignored.
REQ-023 exec_en SHALL be 1 in RUN and STEP, 0 in HALT.
REQ-024 RUN -> HALT when halt_req=1; the instruction at pc in that cycle still executes and pm_addr still advances.
REQ-025 HALT -> RUN when run_req=1; else HALT -> STEP when step_req=1; else remain HALT.
REQ-026 STEP SHALL last exactly one cycle, assert step_ack, advance per REQ-020, then go HALT unconditionally.
REQ-027 step_req held high SHALL produce one step per two cycles (STEP, HALT, STEP ...); run_req SHALL win over step_req.
REQ-028 halt_req, run_req, step_req SHALL be ignored in states where no transition is defined for them.
REQ-029 Unused seq_state encoding 11 SHALL recover to HALT on the next edge.

Reset
REQ-030 While reset=1: pc=8'hFF, seq_state=RUN, pm_addr=8'h00, exec_en=1, step_ack=0, hist_count=0, all history entries 8'h00.
REQ-031 pm_addr SHALL be forced to 8'h00 while reset=1 irrespective of jump inputs; first fetch after release is address 0.
REQ-032 Reset asserted mid-STEP or mid-HALT SHALL abort immediately to the REQ-030 values without any extra step_ack.

Configuration
REQ-033 Macro PS_HISTORY_EN SHALL compile in a 4-entry ring buffer recording pc on every taken jump while exec_en=1.
REQ-034 With PS_HISTORY_EN: hist_data = entry hist_sel (0 newest), hist_count increments per recorded jump, saturates at 4; entries beyond hist_count read 8'h00.
REQ-035 Without PS_HISTORY_EN: no history storage; hist_data=8'h00 and hist_count=3'd0 constantly; hist_sel ignored.

Verification
REQ-036 Release reset, no jumps, 300 cycles -> pm_addr 00,01,...,FF,00,...; pc lags by one cycle; wrap at FF->00.
REQ-037 pc=8'h12, jmp=1, jmp_addr=4'hA -> pm_addr=8'hA0 same cycle, pc=8'hA0 next cycle; same with jmp_nz=1,dont_jmp=1 -> pm_addr=8'h13.
REQ-038 pc=8'h05, halt_req pulse -> pc 06 then held at 06, exec_en=0; step_req one cycle -> step_ack=1, pc 07, back to HALT; run_req -> resumes at 08.
REQ-039 In HALT, step_req and run_req both high -> RUN, no step_ack; step_req held 6 cycles -> exactly 3 step_ack pulses.
REQ-040 Assert reset mid-STEP -> pc=8'hFF, pm_addr=8'h00, seq_state=00 immediately, asynchronously to clk.
REQ-041 PS_HISTORY_EN: jumps taken at pc 10,20,30,40,50 -> hist_count=4, hist_sel 0..3 reads 50,40,30,20; without macro all read 00.

Source files
------------

// File: rtl/program_sequencer_ctrl.sv
// Program sequencer: next-fetch address generation, PC register and RUN/HALT/STEP debug FSM.
// Optional 4-entry jump-history ring buffer compiled in with `define PS_HISTORY_EN.
module program_sequencer_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       jmp,
    input  logic       jmp_nz,
    input  logic [3:0] jmp_addr,
    input  logic       dont_jmp,
    input  logic       halt_req,
    input  logic       run_req,
    input  logic       step_req,
    input  logic [1:0] hist_sel,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic       exec_en,
    output logic       step_ack,
    output logic [1:0] seq_state,
    output logic [7:0] from_PS,
    output logic [7:0] hist_data,
    output logic [2:0] hist_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10,
        ST_BAD  = 2'b11
    } seq_state_t;

    seq_state_t state;
    seq_state_t state_nxt;
    logic       jump_taken;

    // Both jump sources share the same target, so jmp priority needs no extra muxing.
    assign jump_taken = jmp | (jmp_nz & ~dont_jmp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            pc    <= 8'hFF;
        end else begin
            state <= state_nxt;
            pc    <= pm_addr;
        end
    end

    always_comb begin
        state_nxt = state;
        exec_en   = 1'b0;
        step_ack  = 1'b0;
        pm_addr   = pc;
        case (state)
            ST_RUN: begin
                exec_en = 1'b1;
                if (halt_req) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (run_req)       state_nxt = ST_RUN;
                else if (step_req) state_nxt = ST_STEP;
            end
            ST_STEP: begin
                exec_en   = 1'b1;
                step_ack  = 1'b1;
                state_nxt = ST_HALT;
            end
            default: state_nxt = ST_HALT;
        endcase
        if (exec_en) pm_addr = jump_taken ? {jmp_addr, 4'h0} : pc + 8'd1;
        // Reset must win combinationally so the first fetch after release is address 0.
        if (reset) pm_addr = '0;
    end

    assign seq_state = state;
    assign from_PS   = pc;

`ifdef PS_HISTORY_EN
    logic [7:0] hist_mem [4];
    logic [1:0] wr_ptr;
    logic [2:0] count;
    logic [1:0] rd_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) hist_mem[i] <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (exec_en && jump_taken) begin
            hist_mem[wr_ptr] <= pc;
            wr_ptr           <= wr_ptr + 2'd1;
            if (count != 3'd4) count <= count + 3'd1;
        end
    end

    // wr_ptr points at the next free slot; index 0 reads the most recent entry.
    assign rd_idx     = wr_ptr - 2'd1 - hist_sel;
    assign hist_data  = ({1'b0, hist_sel} < count) ? hist_mem[rd_idx] : '0;
    assign hist_count = count;
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_data       = '0;
    assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_program_sequencer_ctrl.sv
// Directed self-checking bench for program_sequencer_ctrl; expectations track PS_HISTORY_EN.
module tb_program_sequencer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       jmp = 1'b0, jmp_nz = 1'b0, dont_jmp = 1'b0;
    logic [3:0] jmp_addr = 4'h0;
    logic       halt_req = 1'b0, run_req = 1'b0, step_req = 1'b0;
    logic [1:0] hist_sel = 2'd0;
    logic [7:0] pm_addr, pc, from_PS, hist_data;
    logic       exec_en, step_ack;
    logic [1:0] seq_state;
    logic [2:0] hist_count;

    int checks = 0;
    int errors = 0;

    program_sequencer_ctrl dut (
        .clk(clk), .reset(reset), .jmp(jmp), .jmp_nz(jmp_nz), .jmp_addr(jmp_addr),
        .dont_jmp(dont_jmp), .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
        .hist_sel(hist_sel), .pm_addr(pm_addr), .pc(pc), .exec_en(exec_en),
        .step_ack(step_ack), .seq_state(seq_state), .from_PS(from_PS),
        .hist_data(hist_data), .hist_count(hist_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; jmp = 1'b1; jmp_addr = 4'hF;
        tick();
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL rst_pc got %h exp %h", pc, 8'hFF); end
        checks++; if (pm_addr !== 8'h00) begin errors++; $display("FAIL rst_pm_addr got %h exp %h", pm_addr, 8'h00); end
        checks++; if (seq_state !== 2'b00) begin errors++; $display("FAIL rst_state got %b exp %b", seq_state, 2'b00); end
        checks++; if (exec_en !== 1'b1) begin errors++; $display("FAIL rst_exec_en got %b exp 1", exec_en); end
        checks++; if (step_ack !== 1'b0) begin errors++; $display("FAIL rst_step_ack got %b exp 0", step_ack); end
        checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL rst_hist_count got %0d exp 0", hist_count); end
        checks++; if (hist_data !== 8'h00) begin errors++; $display("FAIL rst_hist_data got %h exp 00", hist_data); end
        checks++; if (from_PS !== 8'hFF) begin errors++; $display("FAIL rst_from_PS got %h exp FF", from_PS); end
        jmp = 1'b0; jmp_addr = 4'h0;
        reset = 1'b0;
        #1;
        checks++; if (pm_addr !== 8'h00) begin errors++; $display("FAIL rel_pm_addr got %h exp 00", pm_addr); end
        tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL first_fetch_pc got %h exp 00", pc); end
    endtask

    task automatic test_sequential();
        logic [7:0] exp_pm, exp_pc;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            exp_pm = 8'(i);
            exp_pc = 8'(i - 1);
            checks++; if (pm_addr !== exp_pm) begin errors++; $display("FAIL seq_pm_addr[%0d] got %h exp %h", i, pm_addr, exp_pm); end
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp_pc); end
            tick();
        end
    endtask

    task automatic test_jump();
        do_reset();
        jmp = 1'b1; jmp_addr = 4'h1; #1;
        checks++; if (pm_addr !== 8'h10) begin errors++; $display("FAIL jmp_pm_10 got %h exp 10", pm_addr); end
        tick(); jmp = 1'b0;
        tick(); tick();
        checks++; if (pc !== 8'h12) begin errors++; $display("FAIL jmp_pc_12 got %h exp 12", pc); end
        jmp_nz = 1'b1; dont_jmp = 1'b1; jmp_addr = 4'hA; #1;
        checks++; if (pm_addr !== 8'h13) begin errors++; $display("FAIL jnz_suppressed got %h exp 13", pm_addr); end
        jmp_nz = 1'b0; dont_jmp = 1'b0; jmp = 1'b1; #1;
        checks++; if (pm_addr !== 8'hA0) begin errors++; $display("FAIL jmp_pm_A0 got %h exp A0", pm_addr); end
        tick(); jmp = 1'b0; #1;
        checks++; if (pc !== 8'hA0) begin errors++; $display("FAIL jmp_pc_A0 got %h exp A0", pc); end
        jmp_nz = 1'b1; dont_jmp = 1'b0; jmp_addr = 4'h7; #1;
        checks++; if (pm_addr !== 8'h70) begin errors++; $display("FAIL jnz_taken got %h exp 70", pm_addr); end
        tick();
        checks++; if (pc !== 8'h70) begin errors++; $display("FAIL jnz_pc got %h exp 70", pc); end
        jmp = 1'b1; dont_jmp = 1'b1; jmp_addr = 4'h9; #1;
        checks++; if (pm_addr !== 8'h90) begin errors++; $display("FAIL jmp_prio got %h exp 90", pm_addr); end
        jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;
    endtask

    task automatic test_halt_step();
        do_reset();
        step_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        step_req = 1'b0;
        checks++; if (pc !== 8'h05) begin errors++; $display("FAIL hs_pc05 got %h exp 05", pc); end
        checks++; if (seq_state !== 2'b00 || step_ack !== 1'b0) begin errors++; $display("FAIL step_in_run state %b ack %b exp 00 0", seq_state, step_ack); end
        halt_req = 1'b1; #1;
        checks++; if (pm_addr !== 8'h06 || exec_en !== 1'b1) begin errors++; $display("FAIL halt_cycle pm %h en %b exp 06 1", pm_addr, exec_en); end
        tick(); halt_req = 1'b0;
        checks++; if (pc !== 8'h06 || seq_state !== 2'b01 || exec_en !== 1'b0) begin errors++; $display("FAIL halted pc %h st %b en %b exp 06 01 0", pc, seq_state, exec_en); end
        jmp = 1'b1; jmp_addr = 4'hF; halt_req = 1'b1; #1;
        checks++; if (pm_addr !== 8'h06) begin errors++; $display("FAIL halt_ign_jmp got %h exp 06", pm_addr); end
        tick(); jmp = 1'b0; halt_req = 1'b0;
        checks++; if (pc !== 8'h06 || seq_state !== 2'b01) begin errors++; $display("FAIL halt_hold pc %h st %b exp 06 01", pc, seq_state); end
        step_req = 1'b1;
        tick(); step_req = 1'b0;
        checks++; if (seq_state !== 2'b10 || step_ack !== 1'b1 || pm_addr !== 8'h07 || exec_en !== 1'b1) begin errors++; $display("FAIL step st %b ack %b pm %h en %b exp 10 1 07 1", seq_state, step_ack, pm_addr, exec_en); end
        tick();
        checks++; if (pc !== 8'h07 || seq_state !== 2'b01 || step_ack !== 1'b0) begin errors++; $display("FAIL post_step pc %h st %b ack %b exp 07 01 0", pc, seq_state, step_ack); end
        run_req = 1'b1;
        tick(); run_req = 1'b0;
        checks++; if (seq_state !== 2'b00 || pm_addr !== 8'h08) begin errors++; $display("FAIL resume st %b pm %h exp 00 08", seq_state, pm_addr); end
        tick();
        checks++; if (pc !== 8'h08) begin errors++; $display("FAIL resume_pc got %h exp 08", pc); end
    endtask

    task automatic test_step_run_priority();
        int acks = 0;
        do_reset();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        step_req = 1'b1; run_req = 1'b1;
        tick();
        step_req = 1'b0; run_req = 1'b0;
        checks++; if (seq_state !== 2'b00 || step_ack !== 1'b0) begin errors++; $display("FAIL run_wins st %b ack %b exp 00 0", seq_state, step_ack); end
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        step_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (step_ack === 1'b1) acks++;
        end
        step_req = 1'b0;
        checks++; if (acks !== 3) begin errors++; $display("FAIL step_held_acks got %0d exp 3", acks); end
        checks++; if (pc !== 8'h04 || seq_state !== 2'b01) begin errors++; $display("FAIL step_held pc %h st %b exp 04 01", pc, seq_state); end
    endtask

    task automatic test_reset_mid_step();
        do_reset();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        step_req = 1'b1; tick(); step_req = 1'b0;
        checks++; if (seq_state !== 2'b10) begin errors++; $display("FAIL pre_abort_state got %b exp 10", seq_state); end
        #2; reset = 1'b1; #1;
        checks++; if (pc !== 8'hFF || pm_addr !== 8'h00 || seq_state !== 2'b00 || step_ack !== 1'b0) begin errors++; $display("FAIL async_abort pc %h pm %h st %b ack %b exp FF 00 00 0", pc, pm_addr, seq_state, step_ack); end
        tick();
        checks++; if (pc !== 8'hFF || step_ack !== 1'b0 || exec_en !== 1'b1) begin errors++; $display("FAIL abort_hold pc %h ack %b en %b exp FF 0 1", pc, step_ack, exec_en); end
        reset = 1'b0; #1;
    endtask

    task automatic test_history();
        logic [7:0] exp_data [4];
        logic [2:0] exp_cnt;
        logic [7:0] exp_pc;
        do_reset();
        for (int i = 0; i < 17; i++) tick();
        checks++; if (pc !== 8'h10) begin errors++; $display("FAIL hist_start_pc got %h exp 10", pc); end
        for (int n = 1; n <= 5; n++) begin
            jmp = 1'b1; jmp_addr = 4'(n + 1);
            tick(); jmp = 1'b0;
            exp_pc = {4'(n + 1), 4'h0};
`ifdef PS_HISTORY_EN
            exp_cnt = (n > 4) ? 3'd4 : 3'(n);
`else
            exp_cnt = 3'd0;
`endif
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL hist_jmp_pc[%0d] got %h exp %h", n, pc, exp_pc); end
            checks++; if (hist_count !== exp_cnt) begin errors++; $display("FAIL hist_count[%0d] got %0d exp %0d", n, hist_count, exp_cnt); end
            if (n == 2) begin
                hist_sel = 2'd2; #1;
                checks++; if (hist_data !== 8'h00) begin errors++; $display("FAIL hist_beyond_count got %h exp 00", hist_data); end
            end
        end
`ifdef PS_HISTORY_EN
        exp_data = '{8'h50, 8'h40, 8'h30, 8'h20};
`else
        exp_data = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
        for (int s = 0; s < 4; s++) begin
            hist_sel = 2'(s); #1;
            checks++; if (hist_data !== exp_data[s]) begin errors++; $display("FAIL hist_data[%0d] got %h exp %h", s, hist_data, exp_data[s]); end
        end
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        jmp = 1'b1; jmp_addr = 4'hE; tick(); jmp = 1'b0;
        hist_sel = 2'd0; #1;
        checks++; if (hist_data !== exp_data[0]) begin errors++; $display("FAIL hist_halt_jmp got %h exp %h", hist_data, exp_data[0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_halt_step();
        test_step_run_priority();
        test_reset_mid_step();
        test_history();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
